// File: rtl/souper_aud_rx_pkg.sv
// rtl/souper_aud_rx_pkg.sv - shared state encodings, defaults and helpers for the Souper audio receiver
package souper_aud_rx_pkg;

    // Receiver FSM encodings; the mapper side of the port uses the same values
    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_PUSH   = 2'd3
    } aud_state_t;

    localparam int DEF_DEPTH       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SETTLE      = 4;

    // Saturating 8-bit increment used by the lost-command counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/souper_aud_rx_fifo.sv
// rtl/souper_aud_rx_fifo.sv - show-ahead command FIFO with registered head and no bypass
module souper_aud_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [AW:0]      level,
    output logic             full
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic             pop;
    logic             wr_en;
    logic             head_valid_next;

    // Pointers carry an extra MSB so the difference distinguishes full from empty
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == DEPTH_W);
    assign pop   = pop_req & valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en = push & (~full | pop);

    assign rd_next = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    // Head validity ignores this cycle's push: a fresh entry becomes visible one cycle later
    assign head_valid_next = pop ? (level != PTR_ONE) : (level != '0);

    // Storage array; contents are meaningless until written, so it carries no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance and registered show-ahead head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_next;
            valid  <= head_valid_next;
            if (head_valid_next) begin
                dout <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/souper_aud_rx.sv
// rtl/souper_aud_rx.sv - Souper audio port receiver: request resync, edge detect, settle, queue
module souper_aud_rx
    import souper_aud_rx_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SETTLE      = DEF_SETTLE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     aud_req_n,
    input  logic [7:0]               aud_com,
    output logic [7:0]               cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt
);

    localparam int CW = $clog2(SETTLE) + 1;
    localparam int AC = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AC-1:0] ARM_LAST = AC'(SYNC_STAGES);
    localparam logic [AC-1:0] ARM_ONE  = AC'(1);

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   req_ref;
    logic [7:0]             com_s1;
    logic [7:0]             com_s2;
    logic [CW-1:0]          settle_cnt;
    logic [AC-1:0]          arm_cnt;
    logic [7:0]             cmd_byte;
    aud_state_t             state_q;
    aud_state_t             state_d;
    logic                   evt;
    logic                   ref_load;
    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   byte_latch;
    logic                   push;
    logic                   settle_drop;
    logic                   fifo_full;
    logic                   pop;
    logic                   drop;

    // Request line resynchroniser; idles high like the released open-drain line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sync <= '1;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], aud_req_n};
        end
    end

    // Command bus sampler, free-running two-flop pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            com_s1 <= '0;
            com_s2 <= '0;
        end else begin
            com_s1 <= aud_com;
            com_s2 <= com_s1;
        end
    end

    assign req_s = req_sync[SYNC_STAGES-1];
    assign evt   = (req_s != req_ref);
    assign pop   = cmd_valid & cmd_ready;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a fresh edge in SETTLE wins over an expiring count
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:    if (arm_cnt == ARM_LAST) state_d = ST_IDLE;
            ST_IDLE:   if (evt) state_d = ST_SETTLE;
            ST_SETTLE: if (!evt && settle_cnt == '0) state_d = ST_PUSH;
            ST_PUSH:   state_d = ST_IDLE;
            default:   state_d = ST_ARM;
        endcase
    end

    // FSM output decode: datapath strobes per state
    always_comb begin
        ref_load    = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        byte_latch  = 1'b0;
        push        = 1'b0;
        settle_drop = 1'b0;
        case (state_q)
            ST_ARM: begin
                ref_load = 1'b1;
            end
            ST_IDLE: begin
                ref_load = evt;
                cnt_load = evt;
            end
            ST_SETTLE: begin
                if (evt) begin
                    ref_load    = 1'b1;
                    cnt_load    = 1'b1;
                    settle_drop = 1'b1;
                end else if (settle_cnt == '0) begin
                    byte_latch = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_PUSH: begin
                push = 1'b1;
            end
            default: ;
        endcase
    end

    // Reference level, settle timer, arm timer and captured command byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ref    <= 1'b1;
            settle_cnt <= '0;
            arm_cnt    <= '0;
            cmd_byte   <= '0;
        end else begin
            if (ref_load) req_ref <= req_s;
            if (cnt_load) begin
                settle_cnt <= CNT_LOAD;
            end else if (cnt_dec) begin
                settle_cnt <= settle_cnt - CNT_ONE;
            end
            if (state_q == ST_ARM) arm_cnt <= arm_cnt + ARM_ONE;
            if (byte_latch) cmd_byte <= com_s2;
        end
    end

    assign drop = settle_drop | (push & fifo_full & ~pop);

    // Sticky overflow and saturating drop counter; clear beats a simultaneous drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    souper_aud_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (cmd_byte),
        .pop_req   (cmd_ready),
        .dout      (cmd_data),
        .valid     (cmd_valid),
        .level     (fifo_level),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_souper_aud_rx.sv
// tb/tb_souper_aud_rx.sv - self-checking bench for souper_aud_rx
module tb_souper_aud_rx;

    typedef struct {
        logic [7:0] com;
        int         gap;
        bit         lost;
        int         exp_drops;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       aud_req_n = 1'b1;
    logic [7:0] aud_com = 8'h00;
    logic       cmd_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic [4:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_cnt;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    vec_t       vecs[8];

    always #5 clk = ~clk;

    souper_aud_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .aud_req_n  (aud_req_n),
        .aud_com    (aud_com),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit lost);
        aud_com   = b;
        aud_req_n = ~aud_req_n;
        if (!lost) exp_q.push_back(b);
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (fifo_level == 5'd0 && !cmd_valid) break;
            step(1);
        end
        check(name, int'(fifo_level), 0);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h40 + i), 1'b0);
            step(30);
        end
        check("fill_level", int'(fifo_level), 16);
    endtask

    // Scoreboard: every pop the DUT performs must match the oldest expected command
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0h, expected no command", cmd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cmd_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h, expected %0h", cmd_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h11,  2, 1'b1, 0};
        vecs[1] = '{8'h22, 30, 1'b0, 1};
        vecs[2] = '{8'h5A, 30, 1'b0, 1};
        vecs[3] = '{8'hC3,  3, 1'b1, 1};
        vecs[4] = '{8'h3F,  4, 1'b1, 2};
        vecs[5] = '{8'h80, 30, 1'b0, 3};
        vecs[6] = '{8'hFF,  5, 1'b0, 3};
        vecs[7] = '{8'h01, 30, 1'b0, 3};

        // Reset values
        step(3);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_data", int'(cmd_data), 0);
        reset_n = 1'b1;
        step(10);

        // Single command latency: valid 8 clocks after the captured toggle
        send(8'hA5, 1'b0);
        step(8);
        check("lat_valid_early", int'(cmd_valid), 0);
        step(1);
        check("lat_valid", int'(cmd_valid), 1);
        check("lat_data", int'(cmd_data), 8'hA5);
        check("lat_level", int'(fifo_level), 1);
        cmd_ready = 1'b1;
        step(1);
        check("pop_valid", int'(cmd_valid), 0);
        check("pop_level", int'(fifo_level), 0);

        // Line held low through reset produces no command
        reset_n   = 1'b0;
        aud_req_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(40);
        check("low_rst_valid", int'(cmd_valid), 0);
        check("low_rst_level", int'(fifo_level), 0);
        send(8'h3C, 1'b0);
        step(30);
        wait_drain("low_rst_3c", 50);

        // Overflow: 17 commands into a stalled 16-entry FIFO
        cmd_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            send(8'(i), i == 16);
            step(30);
        end
        check("ovf_level", int'(fifo_level), 16);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_drop_cnt", int'(drop_cnt), 1);
        cmd_ready = 1'b1;
        wait_drain("ovf_drain", 100);
        clear_ovf();
        check("clr_overflow", int'(overflow), 0);
        check("clr_drop_cnt", int'(drop_cnt), 0);

        // Table: spacing decides whether the previous command is overwritten
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].com, vecs[v].lost);
            step(vecs[v].gap);
            check($sformatf("vec%0d_drop_cnt", v), int'(drop_cnt), vecs[v].exp_drops);
            check($sformatf("vec%0d_overflow", v), int'(overflow), int'(vecs[v].exp_drops != 0));
        end
        wait_drain("vec_drain", 100);

        // Full FIFO with a pop landing on the same cycle as a push
        clear_ovf();
        cmd_ready = 1'b0;
        fill16();
        send(8'hE0, 1'b0);
        step(7);
        cmd_ready = 1'b1;
        step(1);
        check("fullpop_level", int'(fifo_level), 16);
        check("fullpop_drop_cnt", int'(drop_cnt), 0);
        check("fullpop_overflow", int'(overflow), 0);
        wait_drain("fullpop_drain", 100);

        // ovf_clr coincident with a full-FIFO drop
        cmd_ready = 1'b0;
        fill16();
        send(8'hD1, 1'b1);
        step(30);
        check("drop1_overflow", int'(overflow), 1);
        check("drop1_drop_cnt", int'(drop_cnt), 1);
        send(8'hD2, 1'b1);
        step(7);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("clrdrop_overflow", int'(overflow), 0);
        check("clrdrop_drop_cnt", int'(drop_cnt), 0);
        check("clrdrop_level", int'(fifo_level), 16);
        send(8'hD3, 1'b1);
        step(30);
        check("drop2_drop_cnt", int'(drop_cnt), 1);

        // Reset asserted mid-SETTLE with five entries queued
        cmd_ready = 1'b1;
        step(11);
        cmd_ready = 1'b0;
        check("pre_rst_level", int'(fifo_level), 5);
        send(8'hD4, 1'b1);
        step(4);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", int'(cmd_valid), 0);
        check("async_rst_level", int'(fifo_level), 0);
        check("async_rst_overflow", int'(overflow), 0);
        check("async_rst_drop_cnt", int'(drop_cnt), 0);
        check("async_rst_data", int'(cmd_data), 0);
        exp_q.delete();
        step(2);
        reset_n = 1'b1;
        step(10);
        send(8'h77, 1'b0);
        cmd_ready = 1'b1;
        step(30);
        wait_drain("post_rst_77", 50);
        check("post_rst_drop_cnt", int'(drop_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
